// File: rtl/fma_sched_if.sv
// Command and read-response bus between one requester and the FMA issue scheduler.
// The requester is the master; fma_sched is the slave.
interface fma_sched_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [1:0]  cmd_lane;
  logic [31:0] cmd_x;
  logic [31:0] cmd_y;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_lane;

  modport master (
    output cmd_valid, cmd_op, cmd_lane, cmd_x, cmd_y, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_lane
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_lane, cmd_x, cmd_y, rsp_ready,
    output cmd_ready, rsp_valid, rsp_lane
  );
endinterface

// File: rtl/fma_sched.sv
// Issue scheduler for the 4-lane FMA accumulate datapath: a mul/aln/add token pipeline
// with per-lane hazard stalls, one-cycle lane clears, and drained lane reads.
module fma_sched #(
  parameter int unsigned LANES = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  fma_sched_if.slave       bus,
  output logic             mul_en,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  output logic             aln_en0,
  output logic [LANES-1:0] aln_en1,
  output logic             add_en,
  output logic [LANES-1:0] clr_en,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {StIdle, StDrain, StResp} state_e;

  localparam logic [2:0] OpMac  = 3'd1;
  localparam logic [2:0] OpMac4 = 3'd2;
  localparam logic [2:0] OpClr  = 3'd3;
  localparam logic [2:0] OpRd   = 3'd4;

  state_e           state_q, state_d;
  logic             en_q;
  logic             s0_valid_q, s0_valid_d;
  logic             s1_valid_q, s1_valid_d;
  logic             s2_valid_q, s2_valid_d;
  logic [LANES-1:0] s0_mask_q, s0_mask_d;
  logic [LANES-1:0] s1_mask_q, s1_mask_d;
  logic [31:0]      mul_a_q, mul_a_d;
  logic [31:0]      mul_b_q, mul_b_d;
  logic [LANES-1:0] clr_q, clr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [1:0]       rsp_lane_q, rsp_lane_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] ops_q, ops_d;

  logic [LANES-1:0] lane_oh;
  logic [LANES-1:0] cmd_mask;
  logic             hazard;
  logic             cmd_ready;
  logic             accept;
  logic             issue;
  logic             pipe_empty;

  // Lanes a command would touch; NOP, RD and illegal ops touch none and never stall.
  always_comb begin
    lane_oh  = LANES'(1) << bus.cmd_lane;
    cmd_mask = '0;
    case (bus.cmd_op)
      OpMac, OpClr: cmd_mask = lane_oh;
      OpMac4:       cmd_mask = '1;
      default:      cmd_mask = '0;
    endcase
    // s0/s1 masks are zero whenever their stage is empty.
    hazard     = |(cmd_mask & (s0_mask_q | s1_mask_q));
    cmd_ready  = en_q && (state_q == StIdle) && !hazard;
    accept     = bus.cmd_valid && cmd_ready;
    issue      = accept && ((bus.cmd_op == OpMac) || (bus.cmd_op == OpMac4));
    pipe_empty = !(s0_valid_q || s1_valid_q || s2_valid_q);
  end

  always_comb begin
    s0_valid_d = issue;
    s0_mask_d  = issue ? cmd_mask : '0;
    s1_valid_d = s0_valid_q;
    s1_mask_d  = s0_mask_q;
    s2_valid_d = s1_valid_q;
    mul_a_d    = issue ? bus.cmd_x : mul_a_q;
    mul_b_d    = issue ? bus.cmd_y : mul_b_q;
    clr_d      = (accept && (bus.cmd_op == OpClr)) ? lane_oh : '0;
    err_d      = err_q || (accept && (bus.cmd_op > OpRd));
    // Counted as the token enters the adder, so the count steps with add_en.
    ops_d      = ops_q + CNT_W'(s1_valid_q);
  end

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_lane_d  = rsp_lane_q;
    case (state_q)
      StIdle: begin
        if (accept && (bus.cmd_op == OpRd)) begin
          state_d    = StDrain;
          rsp_lane_d = bus.cmd_lane;
        end
      end
      StDrain: begin
        if (pipe_empty) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      en_q        <= 1'b0;
      s0_valid_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s0_mask_q   <= '0;
      s1_mask_q   <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      clr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_lane_q  <= '0;
      err_q       <= 1'b0;
      ops_q       <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= 1'b1;
      s0_valid_q  <= s0_valid_d;
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      s0_mask_q   <= s0_mask_d;
      s1_mask_q   <= s1_mask_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      clr_q       <= clr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_lane_q  <= rsp_lane_d;
      err_q       <= err_d;
      ops_q       <= ops_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_lane  = rsp_lane_q;
  assign mul_en        = s0_valid_q;
  assign mul_a         = mul_a_q;
  assign mul_b         = mul_b_q;
  assign aln_en0       = s1_valid_q;
  assign aln_en1       = s1_mask_q;
  assign add_en        = s2_valid_q;
  assign clr_en        = clr_q;
  assign busy          = !pipe_empty || (state_q != StIdle);
  assign err           = err_q;
  assign ops_done      = ops_q;

endmodule

// File: tb/tb_fma_sched.sv
// Bench for fma_sched: directed scenario tasks plus a randomized run, all shadowed by a
// cycle-level reference model built from issue times and lane reservations.
module tb_fma_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fma_sched_if bus ();

  logic        mul_en;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        aln_en0;
  logic [3:0]  aln_en1;
  logic        add_en;
  logic [3:0]  clr_en;
  logic        busy;
  logic        err;
  logic [15:0] ops_done;

  fma_sched #(.LANES(4), .CNT_W(16)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .bus      (bus),
    .mul_en   (mul_en),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .aln_en0  (aln_en0),
    .aln_en1  (aln_en1),
    .add_en   (add_en),
    .clr_en   (clr_en),
    .busy     (busy),
    .err      (err),
    .ops_done (ops_done)
  );

  int vectors;
  int miscompares;

  // Reference model: ring of expected per-cycle events, lane reservations, read mode.
  int          cyc;
  bit          e_mul [64];
  logic [3:0]  e_aln [64];
  bit          e_add [64];
  logic [3:0]  e_clr [64];
  int          lane_free [4];
  int          last_issue;
  int          mode;      // 0 idle, 1 waiting for drain, 2 responding
  int          resp_at;
  logic [1:0]  m_lane;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic [15:0] m_ops;
  bit          m_err;
  bit          skip_rdy;
  int          slot;
  logic [3:0]  x_mask;
  logic        x_ready;
  logic        x_busy;
  logic        x_conf;

  function automatic void model_clear();
    for (int i = 0; i < 64; i++) begin
      e_mul[i] = 1'b0;
      e_aln[i] = 4'd0;
      e_add[i] = 1'b0;
      e_clr[i] = 4'd0;
    end
    for (int i = 0; i < 4; i++) lane_free[i] = 0;
    cyc        = 0;
    last_issue = -100;
    mode       = 0;
    resp_at    = 0;
    m_lane     = 2'd0;
    m_a        = 32'd0;
    m_b        = 32'd0;
    m_ops      = 16'd0;
    m_err      = 1'b0;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      model_clear();
      skip_rdy = 1'b1;
      vectors++;
      if ({mul_en, aln_en0, aln_en1, add_en, clr_en, busy, err, bus.cmd_ready, bus.rsp_valid}
          !== 15'd0) begin
        miscompares++;
        $display("FAIL rst_outputs got=%b exp=0", {mul_en, aln_en0, aln_en1, add_en, clr_en,
                 busy, err, bus.cmd_ready, bus.rsp_valid});
      end
      vectors++;
      if (ops_done !== 16'd0) begin
        miscompares++;
        $display("FAIL rst_ops_done got=%h exp=0", ops_done);
      end
      vectors++;
      if ({mul_a, mul_b} !== 64'd0) begin
        miscompares++;
        $display("FAIL rst_operands got=%h exp=0", {mul_a, mul_b});
      end
    end else begin
      slot = cyc % 64;
      if (e_add[slot]) m_ops = m_ops + 16'd1;
      if (mode == 1 && cyc >= resp_at) mode = 2;
      x_busy = e_mul[slot] || (e_aln[slot] != 4'd0) || e_add[slot] || (mode != 0);
      case (bus.cmd_op)
        3'd1, 3'd3: x_mask = 4'b0001 << bus.cmd_lane;
        3'd2:       x_mask = 4'b1111;
        default:    x_mask = 4'b0000;
      endcase
      x_conf = 1'b0;
      for (int i = 0; i < 4; i++) if (x_mask[i] && cyc < lane_free[i]) x_conf = 1'b1;
      x_ready = (mode == 0) && !x_conf;

      vectors++;
      if (mul_en !== e_mul[slot]) begin
        miscompares++;
        $display("FAIL mon_mul_en cyc=%0d got=%b exp=%b", cyc, mul_en, e_mul[slot]);
      end
      vectors++;
      if ({mul_a, mul_b} !== {m_a, m_b}) begin
        miscompares++;
        $display("FAIL mon_operands cyc=%0d got=%h exp=%h", cyc, {mul_a, mul_b}, {m_a, m_b});
      end
      vectors++;
      if ({aln_en0, aln_en1} !== {e_aln[slot] != 4'd0, e_aln[slot]}) begin
        miscompares++;
        $display("FAIL mon_aln cyc=%0d got=%b_%b exp=%b", cyc, aln_en0, aln_en1, e_aln[slot]);
      end
      vectors++;
      if (add_en !== e_add[slot]) begin
        miscompares++;
        $display("FAIL mon_add_en cyc=%0d got=%b exp=%b", cyc, add_en, e_add[slot]);
      end
      vectors++;
      if (clr_en !== e_clr[slot]) begin
        miscompares++;
        $display("FAIL mon_clr_en cyc=%0d got=%b exp=%b", cyc, clr_en, e_clr[slot]);
      end
      vectors++;
      if (ops_done !== m_ops) begin
        miscompares++;
        $display("FAIL mon_ops_done cyc=%0d got=%0d exp=%0d", cyc, ops_done, m_ops);
      end
      vectors++;
      if (err !== m_err) begin
        miscompares++;
        $display("FAIL mon_err cyc=%0d got=%b exp=%b", cyc, err, m_err);
      end
      vectors++;
      if (busy !== x_busy) begin
        miscompares++;
        $display("FAIL mon_busy cyc=%0d got=%b exp=%b", cyc, busy, x_busy);
      end
      vectors++;
      if (bus.rsp_valid !== (mode == 2)) begin
        miscompares++;
        $display("FAIL mon_rsp_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, mode == 2);
      end
      if (mode == 2) begin
        vectors++;
        if (bus.rsp_lane !== m_lane) begin
          miscompares++;
          $display("FAIL mon_rsp_lane cyc=%0d got=%0d exp=%0d", cyc, bus.rsp_lane, m_lane);
        end
      end
      if (!skip_rdy) begin
        vectors++;
        if (bus.cmd_ready !== x_ready) begin
          miscompares++;
          $display("FAIL mon_cmd_ready cyc=%0d got=%b exp=%b", cyc, bus.cmd_ready, x_ready);
        end
      end

      e_mul[slot] = 1'b0;
      e_aln[slot] = 4'd0;
      e_add[slot] = 1'b0;
      e_clr[slot] = 4'd0;
      if (mode == 2) begin
        if (bus.rsp_ready) mode = 0;
      end else if (bus.cmd_valid && x_ready && !skip_rdy) begin
        case (bus.cmd_op)
          3'd1, 3'd2: begin
            m_a = bus.cmd_x;
            m_b = bus.cmd_y;
            e_mul[(cyc + 1) % 64] = 1'b1;
            e_aln[(cyc + 2) % 64] = x_mask;
            e_add[(cyc + 3) % 64] = 1'b1;
            for (int i = 0; i < 4; i++) if (x_mask[i]) lane_free[i] = cyc + 3;
            last_issue = cyc;
          end
          3'd3: e_clr[(cyc + 1) % 64] = x_mask;
          3'd4: begin
            mode    = 1;
            m_lane  = bus.cmd_lane;
            // Response follows both the one-cycle drain and the last adder token.
            resp_at = (cyc + 2 > last_issue + 5) ? cyc + 2 : last_issue + 5;
          end
          3'd5, 3'd6, 3'd7: m_err = 1'b1;
          default: ;
        endcase
      end
      skip_rdy = 1'b0;
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic v, input logic [2:0] op, input logic [1:0] lane,
                           input logic [31:0] x, input logic [31:0] y);
    bus.cmd_valid = v;
    bus.cmd_op    = op;
    bus.cmd_lane  = lane;
    bus.cmd_x     = x;
    bus.cmd_y     = y;
  endtask

  task automatic do_reset();
    drive_cmd(1'b0, 3'd0, 2'd0, 32'd0, 32'd0);
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_cmd(1'b1, 3'd0, 2'd0, 32'd0, 32'd0);
    #1;
    vectors++;
    if (bus.cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_cmd_ready got=%b exp=0", bus.cmd_ready);
    end
    vectors++;
    if ({busy, err, ops_done} !== 18'd0) begin
      miscompares++;
      $display("FAIL reset_state got=%h exp=0", {busy, err, ops_done});
    end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    @(negedge clk);
    vectors++;
    if (bus.cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_nop_ready got=%b exp=1", bus.cmd_ready);
    end
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_mac_single();
    do_reset();
    drive_cmd(1'b1, 3'd1, 2'd2, 32'h3F800000, 32'h40000000);
    @(negedge clk);
    vectors++;
    if (bus.cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mac1_ready got=%b exp=1", bus.cmd_ready);
    end
    tick();
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({mul_en, mul_a, mul_b} !== {1'b1, 32'h3F800000, 32'h40000000}) begin
      miscompares++;
      $display("FAIL mac1_mul got=%b_%h_%h exp=1_3f800000_40000000", mul_en, mul_a, mul_b);
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({aln_en0, aln_en1} !== 5'b1_0100) begin
      miscompares++;
      $display("FAIL mac1_aln got=%b_%b exp=1_0100", aln_en0, aln_en1);
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({add_en, ops_done} !== {1'b1, 16'd1}) begin
      miscompares++;
      $display("FAIL mac1_add got=%b ops=%0d exp=1 ops=1", add_en, ops_done);
    end
    tick();
  endtask

  task automatic test_four_lanes();
    logic [3:0] exp_m;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i < 4) drive_cmd(1'b1, 3'd1, 2'(i), 32'(i + 10), 32'(i + 20));
      else bus.cmd_valid = 1'b0;
      @(negedge clk);
      if (i < 4) begin
        vectors++;
        if (bus.cmd_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL four_ready i=%0d got=%b exp=1", i, bus.cmd_ready);
        end
      end
      if (i >= 2 && i <= 5) begin
        exp_m = 4'b0001 << (i - 2);
        vectors++;
        if (aln_en1 !== exp_m) begin
          miscompares++;
          $display("FAIL four_aln i=%0d got=%b exp=%b", i, aln_en1, exp_m);
        end
      end
      if (i == 6) begin
        vectors++;
        if (ops_done !== 16'd4) begin
          miscompares++;
          $display("FAIL four_ops got=%0d exp=4", ops_done);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_cmd(1'b1, 3'd1, 2'd1, 32'hA, 32'hB);
    for (int i = 0; i < 6; i++) begin
      if (i == 4) bus.cmd_valid = 1'b0;
      @(negedge clk);
      if (i <= 3) begin
        vectors++;
        if (bus.cmd_ready !== (i == 0 || i == 3)) begin
          miscompares++;
          $display("FAIL b2b_ready i=%0d got=%b exp=%b", i, bus.cmd_ready, i == 0 || i == 3);
        end
      end
      if (i == 2 || i == 5) begin
        vectors++;
        if (aln_en1 !== 4'b0010) begin
          miscompares++;
          $display("FAIL b2b_aln i=%0d got=%b exp=0010", i, aln_en1);
        end
      end
      if (i == 3 || i == 4) begin
        vectors++;
        if (aln_en0 !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_aln_gap i=%0d got=%b exp=0", i, aln_en0);
        end
      end
      tick();
    end
  endtask

  task automatic test_rd_drain();
    do_reset();
    drive_cmd(1'b1, 3'd2, 2'd0, 32'h1234, 32'h5678);
    @(negedge clk);
    tick();
    drive_cmd(1'b1, 3'd4, 2'd3, 32'd0, 32'd0);
    @(negedge clk);
    vectors++;
    if (bus.cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_accept got=%b exp=1", bus.cmd_ready);
    end
    tick();
    drive_cmd(1'b1, 3'd1, 2'd0, 32'h9, 32'h9);
    for (int i = 2; i < 12; i++) begin
      bus.rsp_ready = (i == 10);
      @(negedge clk);
      if (i <= 10) begin
        vectors++;
        if (bus.cmd_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL rd_stall i=%0d got=%b exp=0", i, bus.cmd_ready);
        end
      end
      if (i == 3) begin
        vectors++;
        if (add_en !== 1'b1) begin
          miscompares++;
          $display("FAIL rd_add i=%0d got=%b exp=1", i, add_en);
        end
      end
      vectors++;
      if (bus.rsp_valid !== (i >= 5 && i <= 10)) begin
        miscompares++;
        $display("FAIL rd_rsp_valid i=%0d got=%b exp=%b", i, bus.rsp_valid, i >= 5 && i <= 10);
      end
      if (i >= 5 && i <= 10) begin
        vectors++;
        if (bus.rsp_lane !== 2'd3) begin
          miscompares++;
          $display("FAIL rd_rsp_lane i=%0d got=%0d exp=3", i, bus.rsp_lane);
        end
      end
      if (i == 11) begin
        vectors++;
        if (bus.cmd_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL rd_resume got=%b exp=1", bus.cmd_ready);
        end
      end
      tick();
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_illegal_clr();
    do_reset();
    drive_cmd(1'b1, 3'd6, 2'd2, 32'd0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) drive_cmd(1'b1, 3'd3, 2'd0, 32'd0, 32'd0);
      if (i == 2) bus.cmd_valid = 1'b0;
      @(negedge clk);
      if (i <= 1) begin
        vectors++;
        if (bus.cmd_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL ill_ready i=%0d got=%b exp=1", i, bus.cmd_ready);
        end
      end
      vectors++;
      if (err !== (i >= 1)) begin
        miscompares++;
        $display("FAIL ill_err i=%0d got=%b exp=%b", i, err, i >= 1);
      end
      vectors++;
      if (clr_en !== ((i == 2) ? 4'b0001 : 4'b0000)) begin
        miscompares++;
        $display("FAIL ill_clr i=%0d got=%b exp=%b", i, clr_en, (i == 2) ? 4'b0001 : 4'b0000);
      end
      vectors++;
      if (ops_done !== 16'd0) begin
        miscompares++;
        $display("FAIL ill_ops i=%0d got=%0d exp=0", i, ops_done);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_cmd(1'b1, 3'd1, 2'd0, 32'hDEAD, 32'hBEEF);
    tick();
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({mul_en, aln_en0, aln_en1, add_en, clr_en, bus.cmd_ready} !== 12'd0) begin
      miscompares++;
      $display("FAIL mid_enables got=%b exp=0", {mul_en, aln_en0, aln_en1, add_en, clr_en,
               bus.cmd_ready});
    end
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    vectors++;
    if ({busy, ops_done} !== 17'd0) begin
      miscompares++;
      $display("FAIL mid_after got=busy %b ops %0d exp=0 0", busy, ops_done);
    end
    tick();
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      bus.cmd_valid = ($urandom_range(0, 9) < 8);
      if (r < 45)      bus.cmd_op = 3'd1;
      else if (r < 55) bus.cmd_op = 3'd2;
      else if (r < 67) bus.cmd_op = 3'd3;
      else if (r < 75) bus.cmd_op = 3'd4;
      else if (r < 97) bus.cmd_op = 3'd0;
      else             bus.cmd_op = 3'($urandom_range(5, 7));
      bus.cmd_lane  = 2'($urandom_range(0, 3));
      bus.cmd_x     = $urandom;
      bus.cmd_y     = $urandom;
      bus.rsp_ready = 1'($urandom_range(0, 1));
      tick();
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (10) tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    drive_cmd(1'b0, 3'd0, 2'd0, 32'd0, 32'd0);
    bus.rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_mac_single();
    test_four_lanes();
    test_back_to_back();
    test_rd_drain();
    test_illegal_clr();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fma_sched.md
Name: fma_sched

Overview:
- Issue scheduler for the 4-lane FMA accumulate datapath (multiplier -> align/shift -> adder).
- Accepts commands from one requester over a valid/ready handshake and drives the per-stage enables with a 3-stage token pipeline.
- Stalls on per-lane accumulator hazards.
- Drains the pipeline before answering lane reads.

Parameters:
- LANES, 4, number of accumulator lanes; only 4 is supported and it sizes the lane masks.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when both valid and ready are high.
- cmd_op  in  3  0 NOP, 1 MAC, 2 MAC4, 3 CLR, 4 RD; 5-7 illegal.
- cmd_lane  in  2  target lane for MAC/CLR/RD; ignored for MAC4 and NOP.
- cmd_x  in  32  multiplicand.
- cmd_y  in  32  multiplier.
- mul_en  out  1  multiplier stage enable.
- mul_a  out  32  registered cmd_x.
- mul_b  out  32  registered cmd_y.
- aln_en0  out  1  align stage global enable.
- aln_en1  out  4  align stage per-lane enable mask.
- add_en  out  1  adder stage enable.
- clr_en  out  4  per-lane accumulator clear, one-cycle pulse.
- rsp_valid  out  1  read response valid.
- rsp_ready  in  1  read response taken.
- rsp_lane  out  2  lane being read.
- busy  out  1  any stage occupied or FSM not in IDLE.
- err  out  1  sticky illegal-op flag.
- ops_done  out  CNT_W  count of adder-stage completions.

Behaviour:
- Reset (reset low, asynchronous):
  - All outputs 0; cmd_ready = 0 while reset is asserted.
  - Stage tokens, masks, FSM, err and ops_done cleared.
  - Reset mid-operation drops all in-flight tokens; no completion is counted.
- Token pipeline: each stage s0 (mul), s1 (aln), s2 (add) holds a valid bit and a 4-bit lane mask.
- Issue (accepted MAC or MAC4) at cycle T:
  - T+1: mul_en = 1; mul_a/mul_b hold the captured operands.
  - T+2: aln_en0 = 1; aln_en1 = lane mask (one-hot for MAC, 4'b1111 for MAC4).
  - T+3: add_en = 1; ops_done increments by 1 (wraps mod 2^CNT_W).
- Tokens advance every cycle; there is no back-pressure inside the pipeline.
- Hazard: a new MAC/MAC4/CLR is not accepted (cmd_ready = 0) when its mask intersects the mask held in s0 or s1.
  - Consequence: back-to-back MACs to the same lane issue 3 cycles apart.
  - MACs to different lanes issue every cycle.
- CLR, when accepted at T: clr_en = one-hot(cmd_lane) at T+1 only. It creates no pipeline token and does not count in ops_done.
- NOP: accepted whenever the FSM is in IDLE; no effect.
- Illegal op (5-7): accepted; err set and held until reset; otherwise treated as NOP.
- FSM states: IDLE, DRAIN, RESP.
  - IDLE: cmd_ready = !hazard. An accepted RD latches cmd_lane into rsp_lane and moves to DRAIN.
  - DRAIN: cmd_ready = 0. When s0, s1 and s2 are all empty, move to RESP next cycle.
  - RESP: rsp_valid = 1, rsp_lane stable, cmd_ready = 0. Return to IDLE on the cycle after rsp_valid and rsp_ready are both high.
- RD with an empty pipeline: DRAIN lasts exactly 1 cycle, so rsp_valid rises at T+2.
- rsp_valid never drops without the handshake; rsp_ready while not in RESP is ignored.
- busy = s0 | s1 | s2 valid | (state != IDLE).

Test Plan:
- MAC lane 2, x = 0x3F800000, y = 0x40000000 at T -> mul_en at T+1 with mul_a = 0x3F800000, mul_b = 0x40000000; aln_en1 = 4'b0100 at T+2; add_en at T+3; ops_done = 1.
- Four MACs to lanes 0, 1, 2, 3 on consecutive cycles -> cmd_ready stays 1; aln_en1 sequence 0001, 0010, 0100, 1000; ops_done = 4.
- Two MACs to lane 1 presented back-to-back -> second accepted at T+3; aln_en1 = 0010 at T+2 and T+5.
- MAC4 then RD lane 3 -> cmd_ready low until drained; rsp_valid with rsp_lane = 3 only after add_en; with rsp_ready held low for 5 cycles, rsp_valid stays 1 and no command is accepted.
- cmd_op = 6, then CLR lane 0 -> err = 1 and stays 1; clr_en = 0001 for exactly one cycle; ops_done unchanged.
- Reset asserted 1 cycle after a MAC issue -> all enables 0 immediately; after release, ops_done = 0 and busy = 0.
